// File: rtl/add_reducer_pipelined.sv
// Pipelined add-reduction tree with valid/sideband delay line and an output accumulator.
// Optional sticky overflow output: define ADD_REDUCER_OVERFLOW_EN.
module add_reducer_pipelined #(
  parameter int WORD_WIDTH = 36,
  parameter int ADDENDS    = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic [ADDENDS*WORD_WIDTH-1:0] addends,
  input  logic                          acc_en,
  input  logic                          acc_clear,
  output logic                          out_valid,
  output logic [WORD_WIDTH-1:0]         reduction,
  output logic [WORD_WIDTH-1:0]         accumulator
`ifdef ADD_REDUCER_OVERFLOW_EN
  ,
  output logic                          overflow
`endif
);

  function automatic int level_cnt(input int k);
    int n;
    n = ADDENDS;
    for (int j = 0; j < k; j++) n = (n + 1) / 2;
    return n;
  endfunction

  // Bit offset of level k inside the flattened tree bus; level k nodes are WORD_WIDTH+k wide.
  function automatic int level_off(input int k);
    int o;
    o = 0;
    for (int j = 0; j < k; j++) o += level_cnt(j) * (WORD_WIDTH + j);
    return o;
  endfunction

  localparam int LEVELS = (ADDENDS > 1) ? $clog2(ADDENDS) : 0;
  localparam int SUM_W  = WORD_WIDTH + LEVELS;
  localparam int TREE_W = level_off(LEVELS + 1);

  wire [TREE_W-1:0] tree;
  wire [SUM_W-1:0]  sum_full;
  logic             vld_d, en_d, clr_d;
  logic             tree_ovf;
  logic [WORD_WIDTH:0] acc_sum;

  assign tree[ADDENDS*WORD_WIDTH-1:0] = addends;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int NP = level_cnt(k - 1);
    localparam int NC = level_cnt(k);
    localparam int WP = WORD_WIDTH + k - 1;
    localparam int WC = WORD_WIDTH + k;
    localparam int OP = level_off(k - 1);
    localparam int OC = level_off(k);
    for (genvar i = 0; i < NC; i++) begin : g_node
      logic [WC-1:0] node_next;
      logic [WC-1:0] node_q;
      if (2 * i + 1 < NP) begin : g_add
        assign node_next = WC'(tree[OP + 2*i*WP +: WP]) + WC'(tree[OP + (2*i+1)*WP +: WP]);
      end else begin : g_pass
        // Odd leftover element is registered unadded to keep every path the same depth.
        assign node_next = WC'(tree[OP + 2*i*WP +: WP]);
      end
      always_ff @(posedge clock) node_q <= node_next;
      assign tree[OC + i*WC +: WC] = node_q;
    end
  end

  assign sum_full = tree[level_off(LEVELS) +: SUM_W];

  if (LEVELS > 0) begin : g_side
    logic [LEVELS-1:0] vld_q, en_q, clr_q;
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        vld_q <= '0;
        en_q  <= '0;
        clr_q <= '0;
      end else begin
        vld_q[0] <= in_valid;
        en_q[0]  <= in_valid & acc_en;
        clr_q[0] <= in_valid & acc_clear;
        for (int k = 1; k < LEVELS; k++) begin
          vld_q[k] <= vld_q[k-1];
          en_q[k]  <= en_q[k-1];
          clr_q[k] <= clr_q[k-1];
        end
      end
    end
    assign vld_d = vld_q[LEVELS-1];
    assign en_d  = en_q[LEVELS-1];
    assign clr_d = clr_q[LEVELS-1];
    assign tree_ovf = |sum_full[SUM_W-1:WORD_WIDTH];
  end else begin : g_noside
    assign vld_d = in_valid;
    assign en_d  = acc_en;
    assign clr_d = acc_clear;
    assign tree_ovf = 1'b0;
  end

  assign acc_sum = {1'b0, accumulator} + {1'b0, sum_full[WORD_WIDTH-1:0]};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      reduction   <= '0;
      accumulator <= '0;
    end else begin
      out_valid <= vld_d;
      if (vld_d) begin
        reduction <= sum_full[WORD_WIDTH-1:0];
        if (clr_d)
          accumulator <= en_d ? sum_full[WORD_WIDTH-1:0] : '0;
        else if (en_d)
          accumulator <= acc_sum[WORD_WIDTH-1:0];
      end
    end
  end

`ifdef ADD_REDUCER_OVERFLOW_EN
  logic ovf_now;
  assign ovf_now = tree_ovf | (en_d & ~clr_d & acc_sum[WORD_WIDTH]);

  // A clearing vector restarts the sticky flag but still records its own overflow.
  always_ff @(posedge clock) begin
    if (!reset_n)
      overflow <= 1'b0;
    else if (vld_d)
      overflow <= clr_d ? ovf_now : (overflow | ovf_now);
  end
`else
  logic unused_ovf;
  assign unused_ovf = tree_ovf | acc_sum[WORD_WIDTH];
`endif

endmodule

// File: tb/tb_add_reducer_pipelined.sv
// Randomized and directed bench for add_reducer_pipelined at ADDENDS = 8, 5 and 1.
// Checks overflow too when ADD_REDUCER_OVERFLOW_EN is defined.
module tb_add_reducer_pipelined;

  localparam int W = 36;
  localparam int NA[3]  = '{8, 5, 1};
  localparam int LAT[3] = '{4, 4, 1};

  typedef struct packed {
    logic         v;
    logic [W-1:0] r;
    logic [W-1:0] a;
    logic         o;
  } obs_t;

  logic clock = 1'b0;
  logic reset_n, in_valid, acc_en, acc_clear;
  logic [W-1:0] w [8];
  logic [8*W-1:0] add8;
  logic [5*W-1:0] add5;
  logic [W-1:0]   add1;
  logic [2:0]     ov;
  logic [W-1:0]   red [3];
  logic [W-1:0]   acc [3];
`ifdef ADD_REDUCER_OVERFLOW_EN
  logic [2:0]     ovf;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  obs_t         q [3][$];
  logic [W-1:0] m_red [3];
  logic [W-1:0] m_acc [3];
  logic         m_ovf [3];

  always #5 clock = ~clock;

  assign add8 = {w[7], w[6], w[5], w[4], w[3], w[2], w[1], w[0]};
  assign add5 = {w[4], w[3], w[2], w[1], w[0]};
  assign add1 = w[0];

  add_reducer_pipelined #(.WORD_WIDTH(W), .ADDENDS(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .addends(add8),
    .acc_en(acc_en), .acc_clear(acc_clear), .out_valid(ov[0]),
    .reduction(red[0]), .accumulator(acc[0])
`ifdef ADD_REDUCER_OVERFLOW_EN
    , .overflow(ovf[0])
`endif
  );

  add_reducer_pipelined #(.WORD_WIDTH(W), .ADDENDS(5)) dut5 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .addends(add5),
    .acc_en(acc_en), .acc_clear(acc_clear), .out_valid(ov[1]),
    .reduction(red[1]), .accumulator(acc[1])
`ifdef ADD_REDUCER_OVERFLOW_EN
    , .overflow(ovf[1])
`endif
  );

  add_reducer_pipelined #(.WORD_WIDTH(W), .ADDENDS(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .addends(add1),
    .acc_en(acc_en), .acc_clear(acc_clear), .out_valid(ov[2]),
    .reduction(red[2]), .accumulator(acc[2])
`ifdef ADD_REDUCER_OVERFLOW_EN
    , .overflow(ovf[2])
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill(input logic [W-1:0] val);
    for (int i = 0; i < 8; i++) w[i] = val;
  endtask

  task automatic seq(input int base);
    for (int i = 0; i < 8; i++) w[i] = W'(i + base);
  endtask

  // Reference model: each accepted input produces the output state it must cause, queued for its latency.
  always @(posedge clock) begin
    logic         sr, sv, se, sc;
    logic [W-1:0] sw [8];
    logic [63:0]  sum64;
    logic [63:0]  tmp;
    logic         ovf_now;
    obs_t         e;
    sr = reset_n; sv = in_valid; se = acc_en; sc = acc_clear;
    for (int i = 0; i < 8; i++) sw[i] = w[i];
    for (int d = 0; d < 3; d++) begin
      if (!sr) begin
        q[d].delete();
        m_red[d] = '0; m_acc[d] = '0; m_ovf[d] = 1'b0;
        for (int j = 0; j < LAT[d]; j++) q[d].push_back('0);
      end else begin
        if (sv) begin
          sum64 = 0;
          for (int i = 0; i < NA[d]; i++) sum64 += 64'(sw[i]);
          tmp = 64'(m_acc[d]) + 64'(sum64[W-1:0]);
          ovf_now = (sum64 >= (64'd1 << W)) || (se && !sc && tmp >= (64'd1 << W));
          m_red[d] = sum64[W-1:0];
          if (sc) m_acc[d] = se ? sum64[W-1:0] : '0;
          else if (se) m_acc[d] = tmp[W-1:0];
          m_ovf[d] = sc ? ovf_now : (m_ovf[d] | ovf_now);
        end
        e.v = sv; e.r = m_red[d]; e.a = m_acc[d]; e.o = m_ovf[d];
        q[d].push_back(e);
      end
    end
    #2;
    for (int d = 0; d < 3; d++) begin
      if (q[d].size() == LAT[d]) begin
        e = q[d].pop_front();
        chk($sformatf("model_d%0d_valid", d), 64'(ov[d]), 64'(e.v));
        chk($sformatf("model_d%0d_reduction", d), 64'(red[d]), 64'(e.r));
        chk($sformatf("model_d%0d_accumulator", d), 64'(acc[d]), 64'(e.a));
`ifdef ADD_REDUCER_OVERFLOW_EN
        chk($sformatf("model_d%0d_overflow", d), 64'(ovf[d]), 64'(e.o));
`endif
      end
    end
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; acc_en = 1'b0; acc_clear = 1'b0;
    fill('0);
    repeat (3) tick();
    chk("reset_valid", 64'(ov[0]), 64'd0);
    chk("reset_accumulator", 64'(acc[0]), 64'd0);
    reset_n = 1'b1;

    // Single all-ones pulse: 1-cycle latency for one addend, 4 cycles for eight.
    fill(36'd1); in_valid = 1'b1; tick();
    in_valid = 1'b0;
    chk("t1_d1_valid", 64'(ov[2]), 64'd1);
    chk("t1_d1_reduction", 64'(red[2]), 64'd1);
    tick(); tick();
    chk("t1_d8_valid_early", 64'(ov[0]), 64'd0);
    tick();
    chk("t1_d8_valid", 64'(ov[0]), 64'd1);
    chk("t1_d8_reduction", 64'(red[0]), 64'd8);
    chk("t1_d5_reduction", 64'(red[1]), 64'd5);
    tick();
    chk("t1_d8_valid_late", 64'(ov[0]), 64'd0);

    // Back-to-back vectors, no accumulation.
    seq(0); in_valid = 1'b1; tick();
    seq(1); tick();
    in_valid = 1'b0; tick(); tick();
    chk("t2_red_28", 64'(red[0]), 64'd28);
    chk("t2_acc_0a", 64'(acc[0]), 64'd0);
    tick();
    chk("t2_red_36", 64'(red[0]), 64'd36);
    chk("t2_valid", 64'(ov[0]), 64'd1);
    chk("t2_acc_0b", 64'(acc[0]), 64'd0);
    chk("t2_d5_red_15", 64'(red[1]), 64'd15);

    // Clear-and-load, accumulate, bubble carrying sidebands, accumulate.
    seq(1); in_valid = 1'b1; acc_en = 1'b1; acc_clear = 1'b1; tick();
    fill(36'd1); acc_clear = 1'b0; tick();
    in_valid = 1'b0; acc_clear = 1'b1; tick();
    in_valid = 1'b1; acc_clear = 1'b0; tick();
    chk("t3_acc_36", 64'(acc[0]), 64'd36);
    chk("t3_d5_acc_15", 64'(acc[1]), 64'd15);
    in_valid = 1'b0; acc_en = 1'b0; tick();
    chk("t3_acc_44", 64'(acc[0]), 64'd44);
    tick();
    chk("t3_bubble_valid", 64'(ov[0]), 64'd0);
    chk("t3_bubble_acc", 64'(acc[0]), 64'd44);
    tick();
    chk("t3_acc_52", 64'(acc[0]), 64'd52);
    chk("t3_d5_acc_25", 64'(acc[1]), 64'd25);

    // Wrap-around and sticky overflow.
    fill(36'hF_FFFF_FFFF); in_valid = 1'b1; tick();
    fill(36'd1); tick();
    fill('0); acc_clear = 1'b1; tick();
    in_valid = 1'b0; acc_clear = 1'b0; tick();
    chk("t5_red_wrap", 64'(red[0]), 64'hF_FFFF_FFF8);
`ifdef ADD_REDUCER_OVERFLOW_EN
    chk("t5_ovf_set", 64'(ovf[0]), 64'd1);
`endif
    tick();
    chk("t5_red_8", 64'(red[0]), 64'd8);
`ifdef ADD_REDUCER_OVERFLOW_EN
    chk("t5_ovf_sticky", 64'(ovf[0]), 64'd1);
`endif
    tick();
    chk("t5_acc_cleared", 64'(acc[0]), 64'd0);
`ifdef ADD_REDUCER_OVERFLOW_EN
    chk("t5_ovf_cleared", 64'(ovf[0]), 64'd0);
`endif

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      int mode;
      reset_n   = ($urandom_range(0, 99) != 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      acc_en    = ($urandom_range(0, 9) < 6);
      acc_clear = ($urandom_range(0, 9) == 0);
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 8; i++) begin
        if (mode == 0) w[i] = W'($urandom_range(0, 1000));
        else if (mode == 1) w[i] = {4'($urandom_range(0, 15)), $urandom};
        else w[i] = 36'hF_FFFF_FFFF - W'($urandom_range(0, 255));
      end
      tick();
    end
    reset_n = 1'b1;

    // Load nonzero state, then reset two cycles after issuing a vector.
    fill(36'd2); in_valid = 1'b1; acc_en = 1'b1; acc_clear = 1'b1; tick();
    in_valid = 1'b0; acc_en = 1'b0; acc_clear = 1'b0;
    repeat (4) tick();
    chk("t6_pre_acc", 64'(acc[0]), 64'd16);
    fill(36'd3); in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    reset_n = 1'b0; tick();
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("t6_valid", 64'(ov[0]), 64'd0);
      chk("t6_reduction", 64'(red[0]), 64'd0);
      chk("t6_accumulator", 64'(acc[0]), 64'd0);
`ifdef ADD_REDUCER_OVERFLOW_EN
      chk("t6_overflow", 64'(ovf[0]), 64'd0);
`endif
      tick();
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/add_reducer_pipelined.md
Name: add_reducer_pipelined

Overview:
Parametrised, fully pipelined add-reduction tree. It sums ADDENDS unsigned words of WORD_WIDTH into one word per accepted input vector, at a throughput of one vector per cycle. A valid sideband travels through the tree, and an output-stage accumulator keeps a running total across vectors. It is the general-purpose successor to the fixed 8-addend reducer and is used by accelerator datapaths attached to the core's I/O ports.

Parameters:
WORD_WIDTH, 36, width of each addend, of reduction and of accumulator.
ADDENDS, 8, number of addends, any integer >= 1 (not limited to powers of two).
LEVELS, derived = clog2(ADDENDS) (0 when ADDENDS=1), number of registered tree levels; not overridable.

Ports:
clock  in  1  system clock; all state updates on posedge.
reset_n  in  1  synchronous, active-low reset, sampled on posedge clock.
in_valid  in  1  addends vector valid this cycle.
addends  in  ADDENDS*WORD_WIDTH  packed addends; addend i is at [i*WORD_WIDTH +: WORD_WIDTH].
acc_en  in  1  sideband: add this vector's sum into the accumulator.
acc_clear  in  1  sideband: restart the accumulator with this vector.
out_valid  out  1  reduction/accumulator updated for one vector this cycle.
reduction  out  WORD_WIDTH  sum of one vector, modulo 2^WORD_WIDTH.
accumulator  out  WORD_WIDTH  running total, modulo 2^WORD_WIDTH.

Behaviour:
- Reset (reset_n=0 at posedge): all pipeline valid bits, out_valid, reduction, accumulator and any sideband registers go to 0. Reset takes priority over every other input. Vectors in flight are discarded and never reach the output.
- No stall and no backpressure: one vector is accepted every cycle that in_valid=1.
- Tree: level k registers pairwise sums of level k-1. With an odd element count, the last element passes through a register unadded so that every path keeps equal latency.
- in_valid, acc_en and acc_clear are delayed alongside their data, so each takes effect with the result of the vector it arrived with.
- Latency: a vector presented at edge N appears with out_valid=1 after edge N+LEVELS+1. That is 4 cycles for ADDENDS=8 and 1 cycle for ADDENDS=1 (pure output register).
- Output stage, when the delayed valid is 1:
  - reduction <= sum.
  - If clear: accumulator <= (acc_en ? sum : 0).
  - Else if acc_en: accumulator <= accumulator + sum.
  - Else: accumulator holds.
  - out_valid <= 1.
- Output stage, when the delayed valid is 0: out_valid <= 0; reduction and accumulator hold their last values.
- Arithmetic: internal tree nodes are WORD_WIDTH+k bits wide at level k, so no intermediate carry is lost. reduction is the low WORD_WIDTH bits. The accumulator wraps modulo 2^WORD_WIDTH.
- Sidebands accompanying in_valid=0 are ignored, so bubbles never alter the accumulator.
- Back-to-back vectors with acc_en=1 accumulate in order with no hazard: the accumulator is a single-cycle read-modify-write register.

Optional Feature:
ADD_REDUCER_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit).
  - At a valid output it is set to 1 if the full-width tree sum has any bit at or above WORD_WIDTH, or if the accumulator addition carries out.
  - It is sticky: it stays 1 across later vectors.
  - It is cleared by reset, or by a valid vector with acc_clear=1; that vector's own overflow condition is still captured.
- Undefined: port absent; purely modulo arithmetic with no overflow tracking.

Test Plan:
1. WORD_WIDTH=36, ADDENDS=8, addends all 1, single in_valid pulse at edge N -> out_valid=1 after edge N+4 only, reduction=8.
2. Stream addend i = i, then i = i+1, on consecutive cycles, acc_en=0 -> reduction=28 then 36 on consecutive out_valid cycles; accumulator stays 0.
3. acc_clear=1/acc_en=1 with i+1 (36), then two vectors with acc_en=1 of all 1 (8 each), one in_valid=0 bubble between them -> accumulator 36, 44, 52; bubble cycle has out_valid=0 and accumulator holds.
4. ADDENDS=5 and ADDENDS=1 builds: vector {1,2,3,4,5} -> reduction=15 after 4 cycles; single addend 7 -> reduction=7 after 1 cycle.
5. Wrap-around, ADDENDS=8: all addends 2^36-1 -> reduction=2^36-8; with the macro defined, overflow=1 and stays 1 until a valid acc_clear vector of all 0s, which returns it to 0.
6. Reset mid-flight: assert reset_n=0 for one edge 2 cycles after issuing a valid vector -> out_valid never asserts for that vector; reduction=0, accumulator=0 (overflow=0 when the macro is defined).
